serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous to clk, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend, unsigned; captured on accepted start.
REQ-006 b  input  WIDTH  subtrahend, unsigned; captured on accepted start.
REQ-007 busy  output  1  high while in SHIFT or DONE.
REQ-008 done  output  1  one-cycle pulse; result valid.
REQ-009 diff  output  WIDTH  registered result (a-b) mod 2^WIDTH.
REQ-010 borrow_out  output  1  registered final borrow; 1 iff a<b.
REQ-011 zero  output  1  present only when SERIAL_SUB_ZERO_FLAG_EN is defined; 1 iff diff==0.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE; no other reachable state.
REQ-013 IDLE with start=1 at an edge: capture a, b into shift registers; clear internal borrow and bit counter; go to SHIFT.
REQ-014 IDLE with start=0: stay in IDLE; outputs hold.
REQ-015 Each SHIFT edge: one half/full-subtract step on LSBs: d = a0^b0^br; br_next = (~a0&b0)|(~(a0^b0)&br).
REQ-016 Each SHIFT edge: shift operand registers right by 1; shift d into MSB of internal result register; increment counter.
REQ-017 After exactly WIDTH SHIFT edges: go to DONE; the same edge loads diff from the completed result register and borrow_out from br_next.
REQ-018 diff and borrow_out SHALL update only on the edge entering DONE; hold otherwise (no partial results visible).
REQ-019 Latency: done high in the cycle immediately following the WIDTH-th edge after the start-accepting edge.
REQ-020 DONE lasts exactly one cycle; then IDLE unconditionally.
REQ-021 start in SHIFT or DONE SHALL be ignored; a, b changes during SHIFT SHALL not affect the result.
REQ-022 start held high continuously: back-to-back operations, one accepted every WIDTH+2 cycles.
REQ-023 Arithmetic SHALL be unsigned modulo 2^WIDTH; a==b gives diff=0, borrow_out=0.

Reset
REQ-024 rst=1 at an edge: state IDLE, busy=0, done=0, diff=0, borrow_out=0, internal borrow, counter and shift registers 0; zero=1 when present.
REQ-025 rst SHALL take priority over start and over any in-flight operation; an aborted operation produces no done pulse.
REQ-026 First start accepted at the first edge with rst=0.

Configuration
REQ-027 Macro SERIAL_SUB_ZERO_FLAG_EN: when defined, port zero exists, registered, updated on the same edge as diff, reset to 1.
REQ-028 Without SERIAL_SUB_ZERO_FLAG_EN: no zero port, no zero logic; all other behaviour identical.

Verification
REQ-029 WIDTH=8, a=0x5A, b=0x3C, start 1 cycle -> done 8 cycles after accept; diff=0x1E, borrow_out=0.
REQ-030 a=0x00, b=0x01 -> diff=0xFF, borrow_out=1; a=0xFF, b=0x00 -> diff=0xFF, borrow_out=0.
REQ-031 a=b=0xA5 -> diff=0x00, borrow_out=0, zero=1 (macro defined); build without macro compiles without zero port.
REQ-032 start held high, operands change each cycle -> done every 10 cycles; each result matches operands sampled at its accepting edge.
REQ-033 rst asserted at 4th SHIFT edge -> next cycle busy=0, done=0, diff=0; no done pulse; new start afterwards completes normally.
REQ-034 Exhaustive WIDTH=4 sweep of all 256 (a,b) pairs -> diff=(a-b)&0xF and borrow_out=(a<b) for each pair.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one borrow-chain step per clock, LSB first.
// Optional registered zero flag is enabled by defining SERIAL_SUB_ZERO_FLAG_EN.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// SHIFT | one subtract step per edge, WIDTH edges total
// DONE  | result valid, done pulse for one cycle
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;
  logic             last_step;

  always_comb begin
    d_bit     = sa[0] ^ sb[0] ^ br;
    br_next   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    res_next  = {d_bit, res[WIDTH-1:1]};
    last_step = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      zero       <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_next;
          br  <= br_next;
          cnt <= cnt + 1'b1;
          // Results become visible only on the final step.
          if (last_step) begin
            diff       <= res_next;
            borrow_out <= br_next;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero       <= (res_next == '0);
`endif
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit and a 4-bit instance
// against an arithmetic reference model of acceptance timing and results.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st [2];
  logic [31:0] aa [2];
  logic [31:0] bb [2];

  logic       busy8, done8, bo8;
  logic [7:0] d8;
  logic       busy4, done4, bo4;
  logic [3:0] d4;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic z8, z4;
`endif

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st[0]), .a(aa[0][7:0]), .b(bb[0][7:0]),
    .busy(busy8), .done(done8), .diff(d8), .borrow_out(bo8)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    , .zero(z8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(st[1]), .a(aa[1][3:0]), .b(bb[1][3:0]),
    .busy(busy4), .done(done4), .diff(d4), .borrow_out(bo4)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    , .zero(z4)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic        bo;
    int          cyc;
  } exp_t;

  exp_t        q0 [$];
  exp_t        q1 [$];
  int          rem  [2];
  logic [31:0] held [2];
  logic        hbo  [2];
  logic [31:0] pd   [2];
  logic        pb   [2];
  int          cyc = 0;
  bit          mon_on = 0;
  int          compared = 0;
  int          mismatched = 0;

  function automatic int wid(int k);
    return (k == 0) ? 8 : 4;
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s dut%0d: got %0h, expected %0h (cycle %0d)", name, k, act, exp, cyc);
    end
  endtask

  // Reference model: a unit accepts start when free, stays occupied for
  // WIDTH shift cycles plus one done cycle, result is plain modular math.
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        rem[k]  = 0;
        held[k] = '0;
        hbo[k]  = 1'b0;
        if (k == 0) q0.delete(); else q1.delete();
      end else if (rem[k] > 0) begin
        rem[k]--;
        if (rem[k] == 1) begin
          held[k] = pd[k];
          hbo[k]  = pb[k];
        end
      end else if (st[k]) begin
        logic [31:0] m;
        exp_t        e;
        m      = (32'd1 << wid(k)) - 32'd1;
        pd[k]  = ((aa[k] & m) - (bb[k] & m)) & m;
        pb[k]  = (aa[k] & m) < (bb[k] & m);
        e.d    = pd[k];
        e.bo   = pb[k];
        e.cyc  = cyc + wid(k);
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        rem[k] = wid(k) + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      for (int k = 0; k < 2; k++) begin
        logic        bz, dn, bo;
        logic [31:0] dv;
        exp_t        e;
        bz = (k == 0) ? busy8 : busy4;
        dn = (k == 0) ? done8 : done4;
        bo = (k == 0) ? bo8 : bo4;
        dv = (k == 0) ? 32'(d8) : 32'(d4);
        chk("busy", k, 32'(bz), 32'(rem[k] > 0));
        chk("done", k, 32'(dn), 32'(rem[k] == 1));
        chk("diff_hold", k, dv, held[k]);
        chk("borrow_hold", k, 32'(bo), 32'(hbo[k]));
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        chk("zero", k, 32'((k == 0) ? z8 : z4), 32'(held[k] == 32'd0));
`endif
        if (dn) begin
          if ((k == 0 ? q0.size() : q1.size()) == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_done dut%0d: got done=1, expected no pending result (cycle %0d)", k, cyc);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk("sb_diff", k, dv, e.d);
            chk("sb_borrow", k, 32'(bo), 32'(e.bo));
            chk("sb_latency", k, 32'(cyc), 32'(e.cyc));
          end
        end
      end
    end
  end

  task automatic go(int k, logic [31:0] x, logic [31:0] y);
    int t = 0;
    while (rem[k] != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (rem[k] != 0) begin
      compared++;
      mismatched++;
      $display("FAIL go_timeout dut%0d: got rem=%0d, expected 0", k, rem[k]);
    end
    aa[k] = x;
    bb[k] = y;
    st[k] = 1'b1;
    @(posedge clk); #1;
    st[k] = 1'b0;
    aa[k] = $urandom;
    bb[k] = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0; aa[k] = '0; bb[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1;
    rst    = 1'b0;

    go(0, 32'h5A, 32'h3C);
    go(0, 32'h00, 32'h01);
    go(0, 32'hFF, 32'h00);
    go(0, 32'hA5, 32'hA5);
    for (int i = 0; i < 20; i++) go(0, $urandom, $urandom);

    // Random start pulses, including during busy, with churning operands.
    for (int i = 0; i < 300; i++) begin
      st[0] = ($urandom_range(0, 3) == 0);
      aa[0] = $urandom;
      bb[0] = $urandom;
      @(posedge clk); #1;
    end
    st[0] = 1'b0;

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    st[0] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      aa[0] = $urandom;
      bb[0] = $urandom;
      @(posedge clk); #1;
    end
    st[0] = 1'b0;

    // Reset sampled on the 4th SHIFT edge aborts the operation.
    go(0, 32'h80, 32'h01);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    go(0, 32'h33, 32'h44);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        go(1, 32'(x), 32'(y));

    repeat (20) @(posedge clk);
    #1;
    chk("drain_q8", 0, 32'(q0.size()), 32'd0);
    chk("drain_q4", 1, 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
